// File: rtl/node_ctrl_pkg.sv
// Shared types for the node sequencer: opcodes, port codes, FSM states and port-mask helpers.
// Port bit order is LEFT, RIGHT, UP, DOWN; the lowest set bit wins arbitration.
package node_ctrl_pkg;

  localparam int PC_W   = 4;
  localparam int DATA_W = 11;

  typedef logic [PC_W-1:0]          pc_t;
  typedef logic signed [DATA_W-1:0] data_t;

  typedef enum logic [3:0] {
    OP_NOP, OP_MOV, OP_SWP, OP_SAV, OP_ADD, OP_SUB, OP_NEG,
    OP_JMP, OP_JEZ, OP_JNZ, OP_JGZ, OP_JLZ, OP_JRO
  } op_t;

  typedef enum logic [2:0] {
    P_NONE, P_UP, P_DOWN, P_LEFT, P_RIGHT, P_ANY, P_LAST
  } port_t;

  typedef enum logic [1:0] {
    S_EXEC, S_RD2WR, S_WR
  } ctrl_state_t;

  localparam port_t PORT_ORDER [4] = '{P_LEFT, P_RIGHT, P_UP, P_DOWN};

  function automatic logic [3:0] port_mask(input port_t p);
    logic [3:0] m;
    case (p)
      P_LEFT:  m = 4'b0001;
      P_RIGHT: m = 4'b0010;
      P_UP:    m = 4'b0100;
      P_DOWN:  m = 4'b1000;
      P_ANY:   m = 4'b1111;
      default: m = 4'b0000;
    endcase
    return m;
  endfunction

  // One-hot (or any) mask back to a port code; lowest set bit wins.
  function automatic port_t mask_port(input logic [3:0] m);
    port_t p;
    p = P_NONE;
    for (int i = 3; i >= 0; i--) begin
      if (m[i]) p = PORT_ORDER[i];
    end
    return p;
  endfunction

endpackage

// File: rtl/node_ctrl_if.sv
// Decode, port-handshake and pc-control signals between a node sequencer and its surroundings.
interface node_ctrl_if;
  import node_ctrl_pkg::*;

  op_t        op;
  port_t      src_port;
  port_t      dst_port;
  pc_t        pc;
  pc_t        last_pc;
  pc_t        jump_target;
  data_t      acc;
  data_t      src_val;
  logic [3:0] in_valid;
  logic [3:0] in_ready;
  logic [3:0] out_ready;
  logic [3:0] out_valid;
  port_t      rd_sel;
  logic       rd_done;
  logic       hold_we;
  logic       commit;
  logic       halt;
  logic       stall;
  logic       jump_pc_en;
  pc_t        jump_pc;

  modport master (
    input  op, src_port, dst_port, pc, last_pc, jump_target, acc, src_val,
    input  in_valid, out_ready,
    output in_ready, out_valid, rd_sel, rd_done, hold_we,
    output commit, halt, stall, jump_pc_en, jump_pc
  );

  modport slave (
    output op, src_port, dst_port, pc, last_pc, jump_target, acc, src_val,
    output in_valid, out_ready,
    input  in_ready, out_valid, rd_sel, rd_done, hold_we,
    input  commit, halt, stall, jump_pc_en, jump_pc
  );

endinterface

// File: rtl/node_ctrl_port_arb.sv
// Fixed-priority one-hot selector over the four neighbour ports, bit 0 (LEFT) highest.
// Purely combinational; shared between ANY reads and ANY writes.
module node_ctrl_port_arb (
  input  logic [3:0] req,
  output logic [3:0] gnt
);

  always_comb begin
    gnt = 4'b0000;
    for (int i = 3; i >= 0; i--) begin
      if (req[i]) gnt = 4'b0001 << i;
    end
  end

endmodule

// File: rtl/node_ctrl.sv
// Per-node execution sequencer: retires decoded ops, runs port handshakes, drives pc control.
// Reg/imm ops retire in 1 cycle, reads add no latency, writes take 2+ cycles; pc stalls until retire.
module node_ctrl
  import node_ctrl_pkg::*;
(
  input  logic        CLK,
  input  logic        nRST,
  node_ctrl_if.master bus
);

  ctrl_state_t state_q, state_d;
  logic [3:0]  out_valid_q, out_valid_d;
  port_t       last_port_q, last_port_d;
  logic        hold_q, hold_d;

  port_t           src_eff, dst_eff;
  logic            is_rd, is_wr, done, jmp_taken;
  logic [3:0]      rd_mask, arb_req, arb_gnt;
  logic [DATA_W:0] jro_t;
  pc_t             jmp_pc;

  // LAST resolves to the remembered port; an unset LAST acts as NIL.
  always_comb begin
    src_eff = (bus.src_port == P_LAST) ? last_port_q : bus.src_port;
    dst_eff = (bus.dst_port == P_LAST) ? last_port_q : bus.dst_port;
    is_rd   = (bus.op inside {OP_MOV, OP_ADD, OP_SUB, OP_JRO}) && (src_eff != P_NONE);
    is_wr   = (bus.op == OP_MOV) && (dst_eff != P_NONE);
  end

  assign rd_mask = (state_q == S_EXEC && is_rd) ? port_mask(src_eff) : 4'b0000;
  assign arb_req = (state_q == S_WR) ? (bus.out_ready & out_valid_q) : (rd_mask & bus.in_valid);

  node_ctrl_port_arb u_port_arb (
    .req (arb_req),
    .gnt (arb_gnt)
  );

  always_comb begin
    state_d     = state_q;
    out_valid_d = out_valid_q;
    last_port_d = last_port_q;
    hold_d      = hold_q;
    bus.hold_we = 1'b0;
    done        = 1'b0;
    case (state_q)
      S_EXEC: begin
        if (is_rd) begin
          if (|arb_req) begin
            if (src_eff == P_ANY) last_port_d = mask_port(arb_gnt);
            if (is_wr) begin
              bus.hold_we = 1'b1;
              hold_d      = 1'b1;
              state_d     = S_RD2WR;
            end else begin
              done = 1'b1;
            end
          end
        end else if (is_wr) begin
          out_valid_d = port_mask(dst_eff);
          state_d     = S_WR;
        end else begin
          done = 1'b1;
        end
      end
      S_RD2WR: begin
        if (hold_q) begin
          out_valid_d = port_mask(dst_eff);
          state_d     = S_WR;
        end else begin
          state_d = S_EXEC;
        end
      end
      S_WR: begin
        if (|arb_gnt) begin
          if (dst_eff == P_ANY) last_port_d = mask_port(arb_gnt);
          done        = 1'b1;
          out_valid_d = 4'b0000;
          hold_d      = 1'b0;
          state_d     = S_EXEC;
        end
      end
      default: state_d = S_EXEC;
    endcase
  end

  // JRO sums at DATA_W+1 bits so neither the signed offset nor the pc can overflow.
  always_comb begin
    jro_t     = {{(DATA_W+1-PC_W){1'b0}}, bus.pc} + {bus.src_val[DATA_W-1], bus.src_val};
    jmp_taken = 1'b0;
    jmp_pc    = bus.jump_target;
    case (bus.op)
      OP_JMP: jmp_taken = 1'b1;
      OP_JEZ: jmp_taken = (bus.acc == '0);
      OP_JNZ: jmp_taken = (bus.acc != '0);
      OP_JGZ: jmp_taken = !bus.acc[DATA_W-1] && (bus.acc != '0);
      OP_JLZ: jmp_taken = bus.acc[DATA_W-1];
      OP_JRO: begin
        jmp_taken = 1'b1;
        if (jro_t[DATA_W])
          jmp_pc = '0;
        else if (jro_t[DATA_W-1:0] > {{(DATA_W-PC_W){1'b0}}, bus.last_pc})
          jmp_pc = bus.last_pc;
        else
          jmp_pc = jro_t[PC_W-1:0];
      end
      default: jmp_taken = 1'b0;
    endcase
  end

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      state_q     <= S_EXEC;
      out_valid_q <= 4'b0000;
      last_port_q <= P_NONE;
      hold_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      out_valid_q <= out_valid_d;
      last_port_q <= last_port_d;
      hold_q      <= hold_d;
    end
  end

  assign bus.in_ready   = rd_mask;
  assign bus.rd_done    = |(rd_mask & bus.in_valid);
  assign bus.rd_sel     = bus.rd_done ? mask_port(arb_gnt) : P_NONE;
  // ANY offers to the single best ready neighbour so exactly one transfer happens.
  assign bus.out_valid  = (state_q == S_WR && dst_eff == P_ANY) ? arb_gnt : out_valid_q;
  assign bus.commit     = done;
  assign bus.stall      = !done;
  assign bus.jump_pc_en = done && jmp_taken;
  assign bus.halt       = done && !jmp_taken && (bus.pc == bus.last_pc);
  assign bus.jump_pc    = jmp_pc;

endmodule

// File: tb/tb_node_ctrl.sv
// Directed bench for node_ctrl with a small pc register reacting to halt/stall/jump.
module tb_node_ctrl;
  import node_ctrl_pkg::*;

  logic clk = 1'b0;
  logic nrst;
  logic pc_set_en;
  pc_t  pc_set_val;
  pc_t  pc_q;
  int   n_chk  = 0;
  int   n_pass = 0;

  op_t   cond_op  [7] = '{OP_JEZ, OP_JEZ, OP_JNZ, OP_JNZ, OP_JGZ, OP_JLZ, OP_JLZ};
  data_t cond_acc [7] = '{11'sd0, 11'sd5, 11'sd0, -11'sd1, 11'sd0, -11'sd1, 11'sd0};
  logic  cond_tk  [7] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0};
  data_t jro_off  [6] = '{-11'sd20, 11'sd999, 11'sd0, -11'sd7, 11'sd2, -11'sd3};
  pc_t   jro_exp  [6] = '{4'd0, 4'd9, 4'd7, 4'd0, 4'd9, 4'd4};

  node_ctrl_if bus ();

  node_ctrl dut (
    .CLK  (clk),
    .nRST (nrst),
    .bus  (bus)
  );

  always #5 clk = ~clk;

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst)               pc_q <= '0;
    else if (pc_set_en)      pc_q <= pc_set_val;
    else if (bus.jump_pc_en) pc_q <= bus.jump_pc;
    else if (bus.halt)       pc_q <= '0;
    else if (!bus.stall)     pc_q <= pc_q + 4'd1;
  end
  assign bus.pc = pc_q;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", tag, got, exp);
  endtask

  task automatic nxt();
    @(posedge clk);
    #1;
  endtask

  task automatic set_pc(input pc_t v);
    bus.op        = OP_NOP;
    bus.src_port  = P_NONE;
    bus.dst_port  = P_NONE;
    bus.in_valid  = 4'b0000;
    bus.out_ready = 4'b0000;
    pc_set_val    = v;
    pc_set_en     = 1'b1;
    nxt();
    pc_set_en = 1'b0;
  endtask

  initial begin
    nrst            = 1'b1;
    pc_set_en       = 1'b0;
    pc_set_val      = '0;
    bus.op          = OP_NOP;
    bus.src_port    = P_NONE;
    bus.dst_port    = P_NONE;
    bus.last_pc     = 4'd15;
    bus.jump_target = '0;
    bus.acc         = '0;
    bus.src_val     = '0;
    bus.in_valid    = 4'b0000;
    bus.out_ready   = 4'b0000;
    #1 nrst = 1'b0;
    #2;
    check_eq("rst_out_valid", 32'(bus.out_valid), 0);
    check_eq("rst_state", 32'(dut.state_q), 32'(S_EXEC));
    check_eq("rst_last_port", 32'(dut.last_port_q), 32'(P_NONE));
    check_eq("rst_hold", 32'(dut.hold_q), 0);
    nxt();
    nrst = 1'b1;

    // Write to RIGHT held off for 5 cycles
    set_pc(4'd3);
    bus.op = OP_MOV; bus.dst_port = P_RIGHT;
    @(negedge clk);
    check_eq("t1_exec_stall", 32'(bus.stall), 1);
    check_eq("t1_exec_ov", 32'(bus.out_valid), 0);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      check_eq("t1_wr_stall", 32'(bus.stall), 1);
      check_eq("t1_wr_ov", 32'(bus.out_valid), 2);
    end
    nxt();
    bus.out_ready = 4'b0010;
    @(negedge clk);
    check_eq("t1_commit", 32'(bus.commit), 1);
    check_eq("t1_stall", 32'(bus.stall), 0);
    check_eq("t1_ov_xfer", 32'(bus.out_valid), 2);
    nxt();
    bus.out_ready = 4'b0000; bus.op = OP_NOP; bus.dst_port = P_NONE;
    @(negedge clk);
    check_eq("t1_pc_next", 32'(bus.pc), 4);
    check_eq("t1_ov_clear", 32'(bus.out_valid), 0);

    // MOV LEFT,DOWN: read at cycle 3, write accepted at cycle 6
    set_pc(4'd4);
    bus.op = OP_MOV; bus.src_port = P_LEFT; bus.dst_port = P_DOWN;
    for (int c = 0; c < 7; c++) begin
      bus.in_valid  = (c == 3) ? 4'b0001 : 4'b0000;
      bus.out_ready = (c == 6) ? 4'b1000 : 4'b0000;
      @(negedge clk);
      check_eq("t2_commit", 32'(bus.commit), 32'(c == 6));
      check_eq("t2_hold_we", 32'(bus.hold_we), 32'(c == 3));
      check_eq("t2_in_ready", 32'(bus.in_ready), (c <= 3) ? 1 : 0);
      check_eq("t2_out_valid", 32'(bus.out_valid), (c >= 5) ? 8 : 0);
      if (c == 3) check_eq("t2_rd_sel", 32'(bus.rd_sel), 32'(P_LEFT));
      if (c == 4) check_eq("t2_state_rd2wr", 32'(dut.state_q), 32'(S_RD2WR));
      if (c == 5) check_eq("t2_state_wr", 32'(dut.state_q), 32'(S_WR));
      nxt();
    end
    bus.op = OP_NOP; bus.in_valid = 4'b0000; bus.out_ready = 4'b0000;
    @(negedge clk);
    check_eq("t2_pc_next", 32'(bus.pc), 5);

    // ANY read with DOWN and UP valid, then LAST follows UP
    nxt();
    bus.op = OP_MOV; bus.src_port = P_ANY; bus.dst_port = P_NONE; bus.in_valid = 4'b1100;
    @(negedge clk);
    check_eq("t3_any_in_ready", 32'(bus.in_ready), 15);
    check_eq("t3_any_rd_sel", 32'(bus.rd_sel), 32'(P_UP));
    check_eq("t3_any_commit", 32'(bus.commit), 1);
    nxt();
    bus.src_port = P_LAST; bus.in_valid = 4'b1000;
    @(negedge clk);
    check_eq("t3_last_in_ready", 32'(bus.in_ready), 4);
    check_eq("t3_last_wait", 32'(bus.rd_done), 0);
    check_eq("t3_last_stall", 32'(bus.stall), 1);
    nxt();
    bus.in_valid = 4'b1100;
    @(negedge clk);
    check_eq("t3_last_rd_sel", 32'(bus.rd_sel), 32'(P_UP));
    check_eq("t3_last_commit", 32'(bus.commit), 1);

    // ANY write picks RIGHT out of RIGHT/UP ready
    nxt();
    bus.src_port = P_NONE; bus.in_valid = 4'b0000; bus.dst_port = P_ANY;
    @(negedge clk);
    check_eq("t3w_exec_ov", 32'(bus.out_valid), 0);
    nxt();
    bus.out_ready = 4'b0110;
    @(negedge clk);
    check_eq("t3w_ov", 32'(bus.out_valid), 2);
    check_eq("t3w_commit", 32'(bus.commit), 1);
    nxt();
    bus.out_ready = 4'b0000; bus.dst_port = P_NONE; bus.src_port = P_LAST; bus.in_valid = 4'b0001;
    @(negedge clk);
    check_eq("t3w_last_in_ready", 32'(bus.in_ready), 2);
    check_eq("t3w_last_rd_done", 32'(bus.rd_done), 0);

    // Wrap at last_pc and conditional jumps
    bus.last_pc = 4'd5;
    set_pc(4'd5);
    @(negedge clk);
    check_eq("t4_nop_halt", 32'(bus.halt), 1);
    nxt();
    @(negedge clk);
    check_eq("t4_pc_wrap", 32'(bus.pc), 0);
    set_pc(4'd5);
    bus.op = OP_JGZ; bus.jump_target = 4'd2; bus.acc = -11'sd3;
    @(negedge clk);
    check_eq("t4_jgz_neg_halt", 32'(bus.halt), 1);
    check_eq("t4_jgz_neg_en", 32'(bus.jump_pc_en), 0);
    set_pc(4'd5);
    bus.op = OP_JGZ; bus.acc = 11'sd3;
    @(negedge clk);
    check_eq("t4_jgz_pos_en", 32'(bus.jump_pc_en), 1);
    check_eq("t4_jgz_pos_pc", 32'(bus.jump_pc), 2);
    check_eq("t4_jgz_pos_halt", 32'(bus.halt), 0);
    nxt();
    bus.op = OP_NOP;
    @(negedge clk);
    check_eq("t4_pc_jumped", 32'(bus.pc), 2);
    for (int i = 0; i < 7; i++) begin
      nxt();
      bus.op = cond_op[i]; bus.acc = cond_acc[i];
      @(negedge clk);
      check_eq("t4_cond_taken", 32'(bus.jump_pc_en), 32'(cond_tk[i]));
    end

    // JRO clamping
    bus.last_pc = 4'd9;
    for (int i = 0; i < 6; i++) begin
      set_pc(4'd7);
      bus.op = OP_JRO; bus.src_val = jro_off[i];
      @(negedge clk);
      check_eq("t5_jro_en", 32'(bus.jump_pc_en), 1);
      check_eq("t5_jro_pc", 32'(bus.jump_pc), 32'(jro_exp[i]));
    end
    set_pc(4'd7);
    bus.op = OP_JRO; bus.src_val = 11'sd0;
    nxt();
    @(negedge clk);
    check_eq("t5_jro_spin", 32'(bus.pc), 7);
    set_pc(4'd7);
    bus.op = OP_JRO; bus.src_port = P_LEFT; bus.src_val = 11'sd1;
    @(negedge clk);
    check_eq("t5_jro_port_wait", 32'(bus.stall), 1);
    check_eq("t5_jro_port_noen", 32'(bus.jump_pc_en), 0);
    nxt();
    bus.in_valid = 4'b0001;
    @(negedge clk);
    check_eq("t5_jro_port_en", 32'(bus.jump_pc_en), 1);
    check_eq("t5_jro_port_pc", 32'(bus.jump_pc), 8);

    // Reset during S_WR of a MOV LEFT,UP, then LAST is NIL again
    bus.last_pc = 4'd15;
    set_pc(4'd2);
    bus.op = OP_MOV; bus.src_port = P_LEFT; bus.dst_port = P_UP; bus.in_valid = 4'b0001;
    @(negedge clk);
    check_eq("t6_hold_we", 32'(bus.hold_we), 1);
    nxt();
    bus.in_valid = 4'b0000;
    @(negedge clk);
    @(negedge clk);
    check_eq("t6_wr_ov", 32'(bus.out_valid), 4);
    #2 nrst = 1'b0;
    #1;
    check_eq("t6_rst_ov", 32'(bus.out_valid), 0);
    check_eq("t6_rst_state", 32'(dut.state_q), 32'(S_EXEC));
    check_eq("t6_rst_hold", 32'(dut.hold_q), 0);
    nxt();
    nrst = 1'b1;
    bus.op = OP_MOV; bus.src_port = P_LAST; bus.dst_port = P_NONE; bus.in_valid = 4'b1111;
    @(negedge clk);
    check_eq("t6_pc_restart", 32'(bus.pc), 0);
    check_eq("t6_last_nil_commit", 32'(bus.commit), 1);
    check_eq("t6_last_nil_in_ready", 32'(bus.in_ready), 0);
    check_eq("t6_out_valid_idle", 32'(bus.out_valid), 0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
